rou_buf_alloc: RTL and testbench
================================

Name: rou_buf_alloc

Overview:
Allocator and scheduler for the shared message-buffer pool inside a rou switch. Up to two inputs request a free slot each cycle, and the block returns distinct slot indices using rotating-priority fairness. Up to two outputs release slots each cycle once their message has been drained. It owns the occupancy bitmap, the free count and error flags, and replaces ad-hoc occupancy logic in switch datapaths.

Parameters:
BUFS, 8, number of buffer slots (power of 2, 4..64)
WBUFS, 3+$clog2(BUFS), width of a slot index; all-ones (NOTLEGAL) means "no slot"
LOWMARK, 2, free-count threshold for almost_empty

Ports:
clk  input  1  single clock
rst  input  1  synchronous reset, active-high
softreset  input  1  synchronous pool flush, same effect as rst
req0  input  1  allocation request, input 0
req1  input  1  allocation request, input 1
gnt0  output  1  slot granted to req0 this cycle
gnt1  output  1  slot granted to req1 this cycle
idx0  output  WBUFS  granted slot for req0; NOTLEGAL when gnt0=0
idx1  output  WBUFS  granted slot for req1; NOTLEGAL when gnt1=0
rel0  input  1  release strobe, output 0
rel0_idx  input  WBUFS  slot released by output 0
rel1  input  1  release strobe, output 1
rel1_idx  input  WBUFS  slot released by output 1
free_count  output  $clog2(BUFS)+1  registered number of free slots
almost_empty  output  1  registered, free_count <= LOWMARK
alloc_fail  output  1  registered pulse: a request was not granted in the previous cycle
rel_err  output  1  registered pulse: an illegal release occurred in the previous cycle

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset / softreset (synchronous, rst dominant):
  - occupied=0, rr_ptr=0, prio=0.
  - free_count=BUFS, almost_empty=0, alloc_fail=0, rel_err=0.
  - While rst or softreset is high: gnt0=gnt1=0 and idx0=idx1=NOTLEGAL. Requests and releases in that cycle are discarded.
- Slot search (combinational from registered state only, zero latency):
  - F0 = first free slot scanning upward from rr_ptr, wrapping modulo BUFS.
  - F1 = the next free slot after F0 in the same scan.
  - Each is NOTLEGAL if it does not exist.
- Grant rules (same cycle as the request):
  - Only req0 high: it gets F0 if legal.
  - Only req1 high: it gets F0 if legal.
  - Both high: the prio holder (prio=0 means req0) gets F0 and the other gets F1. If only F0 exists, only the prio holder is granted.
  - gnt0 and gnt1 never carry the same index.
- Contest state:
  - prio toggles after every cycle in which both requested, whether or not both were granted.
  - rr_ptr <= (highest-scan-order granted index + 1) mod BUFS whenever at least one grant occurs. Otherwise rr_ptr holds.
- Release rules:
  - A release is legal only if its index < BUFS and the slot is currently occupied.
  - Illegal releases are ignored and produce rel_err=1 the next cycle.
  - rel0 and rel1 with the same legal index in one cycle: the slot is cleared once, and rel_err=1 next cycle.
- Occupancy update: occupied <= (occupied & ~legal_release_mask) | grant_mask.
  - A slot released in cycle N is visible as free only from cycle N+1. It is never re-granted in cycle N.
  - Grant and release of different slots in the same cycle are both applied.
- Status outputs:
  - free_count <= BUFS - popcount(next occupied). Registered, so it tracks occupied with no extra lag.
  - almost_empty <= (next free_count <= LOWMARK).
  - alloc_fail <= (req0 & !gnt0) | (req1 & !gnt1). This includes the full-pool case.
- Full pool: F0=F1=NOTLEGAL, so all requests are refused. Allocation resumes the cycle after a legal release.
- softreset mid-operation: all slots are freed immediately. Outstanding indices held by the datapath become stale; releasing them afterwards raises rel_err.

Test Plan:
- Reset then req0=1 for 8 consecutive cycles (BUFS=8) -> idx0=0,1,...,7 with gnt0=1 each cycle; 9th cycle gnt0=0, idx0=NOTLEGAL(63); alloc_fail=1 next cycle; free_count=0, almost_empty=1.
- Empty pool, req0=req1=1 for 4 cycles -> cycle0 idx0=0, idx1=1; cycle1 (prio=1) idx1=2, idx0=3; cycle2 idx0=4, idx1=5; cycle3 idx1=6, idx0=7; free_count=0.
- Pool full except slot 5, req0=req1=1, prio=0 -> gnt0=1, idx0=5, gnt1=0; next cycle alloc_fail=1 and prio=1; repeat after releasing slot 5 -> gnt1=1, idx1=5.
- Full pool, rel0=1 with rel0_idx=3 and req0=1 in the same cycle -> gnt0=0 that cycle; next cycle req0 gives idx0=3, gnt0=1.
- rel0=rel1=1 with both indices 2 (occupied), then rel0_idx=2 again, then rel1_idx=9 -> slot 2 freed once; free_count rises by exactly 1; rel_err=1 on each of the three following cycles.
- 5 slots allocated, assert softreset one cycle with req0=1 -> gnt0=0; next cycle free_count=8, req0 gives idx0=0; rst asserted mid-burst behaves identically.

Source files
------------

// File: rtl/rou_buf_alloc.sv
// Shared message-buffer pool allocator: two requesters get distinct free slots
// per cycle via a rotating scan, and two drains release slots back to the pool.
`timescale 1ns/1ps
module rou_buf_alloc #(
    parameter int BUFS    = 8,
    parameter int WBUFS   = 3 + $clog2(BUFS),
    parameter int LOWMARK = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   softreset,
    input  logic                   req0,
    input  logic                   req1,
    output logic                   gnt0,
    output logic                   gnt1,
    output logic [WBUFS-1:0]       idx0,
    output logic [WBUFS-1:0]       idx1,
    input  logic                   rel0,
    input  logic [WBUFS-1:0]       rel0_idx,
    input  logic                   rel1,
    input  logic [WBUFS-1:0]       rel1_idx,
    output logic [$clog2(BUFS):0]  free_count,
    output logic                   almost_empty,
    output logic                   alloc_fail,
    output logic                   rel_err
);
    localparam int LB = $clog2(BUFS);
    localparam int CW = LB + 1;
    localparam logic [WBUFS-1:0] NOTLEGAL = '1;
    localparam logic [BUFS-1:0]  ONE_HOT0 = {{(BUFS-1){1'b0}}, 1'b1};

    logic [BUFS-1:0] occupied_q, occupied_d;
    logic [LB-1:0]   rr_ptr_q, rr_ptr_d;
    logic            prio_q, prio_d;
    logic [CW-1:0]   free_count_q, free_count_d;
    logic            almost_empty_q, almost_empty_d;
    logic            alloc_fail_q, alloc_fail_d;
    logic            rel_err_q, rel_err_d;

    logic            flush;
    logic [BUFS-1:0] rot_free;
    logic            f0_ok, f1_ok;
    logic [LB-1:0]   f0_off, f1_off, f0_slot, f1_slot;
    logic [LB-1:0]   g0_slot, g1_slot, last_slot;
    logic [BUFS-1:0] grant_mask, rel_mask;
    logic            rel0_ok, rel1_ok, rel_dup;
    logic [LB-1:0]   rel0_slot, rel1_slot;
    logic [CW-1:0]   occ_cnt;

    assign flush = rst | softreset;

    // Free vector rotated so that bit 0 is the slot at rr_ptr.
    for (genvar gi = 0; gi < BUFS; gi++) begin : g_rot
        logic [LB-1:0] pos;
        assign pos          = rr_ptr_q + LB'(gi);
        assign rot_free[gi] = ~occupied_q[pos];
    end

    always_comb begin
        f0_ok  = 1'b0;
        f1_ok  = 1'b0;
        f0_off = '0;
        f1_off = '0;
        for (int i = 0; i < BUFS; i++) begin
            if (rot_free[i]) begin
                if (!f0_ok) begin
                    f0_ok  = 1'b1;
                    f0_off = LB'(i);
                end else if (!f1_ok) begin
                    f1_ok  = 1'b1;
                    f1_off = LB'(i);
                end
            end
        end
    end

    assign f0_slot = rr_ptr_q + f0_off;
    assign f1_slot = rr_ptr_q + f1_off;

    always_comb begin
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        g0_slot = f0_slot;
        g1_slot = f0_slot;
        if (!flush) begin
            if (req0 && req1) begin
                if (!prio_q) begin
                    gnt0    = f0_ok;
                    gnt1    = f1_ok;
                    g1_slot = f1_slot;
                end else begin
                    gnt1    = f0_ok;
                    gnt0    = f1_ok;
                    g0_slot = f1_slot;
                end
            end else if (req0) begin
                gnt0 = f0_ok;
            end else if (req1) begin
                gnt1 = f0_ok;
            end
        end
    end

    assign idx0 = gnt0 ? {{(WBUFS-LB){1'b0}}, g0_slot} : NOTLEGAL;
    assign idx1 = gnt1 ? {{(WBUFS-LB){1'b0}}, g1_slot} : NOTLEGAL;

    assign grant_mask = (gnt0 ? (ONE_HOT0 << g0_slot) : '0)
                      | (gnt1 ? (ONE_HOT0 << g1_slot) : '0);
    // F1 is only ever handed out alongside F0, so it is the furthest in scan order.
    assign last_slot  = (gnt0 && gnt1) ? f1_slot : f0_slot;

    assign rel0_slot = rel0_idx[LB-1:0];
    assign rel1_slot = rel1_idx[LB-1:0];
    assign rel0_ok   = rel0 && (rel0_idx < WBUFS'(BUFS)) && occupied_q[rel0_slot];
    assign rel1_ok   = rel1 && (rel1_idx < WBUFS'(BUFS)) && occupied_q[rel1_slot];
    assign rel_dup   = rel0_ok && rel1_ok && (rel0_slot == rel1_slot);
    assign rel_mask  = (rel0_ok ? (ONE_HOT0 << rel0_slot) : '0)
                     | (rel1_ok ? (ONE_HOT0 << rel1_slot) : '0);

    always_comb begin
        occupied_d = (occupied_q & ~rel_mask) | grant_mask;
        rr_ptr_d   = (gnt0 || gnt1) ? last_slot + LB'(1) : rr_ptr_q;
        prio_d     = (req0 && req1) ? ~prio_q : prio_q;
        occ_cnt    = '0;
        for (int i = 0; i < BUFS; i++) begin
            occ_cnt = occ_cnt + CW'(occupied_d[i]);
        end
        free_count_d   = CW'(BUFS) - occ_cnt;
        almost_empty_d = (free_count_d <= CW'(LOWMARK));
        alloc_fail_d   = (req0 && !gnt0) || (req1 && !gnt1);
        rel_err_d      = (rel0 && !rel0_ok) || (rel1 && !rel1_ok) || rel_dup;
    end

    always_ff @(posedge clk) begin
        if (rst || softreset) begin
            occupied_q     <= '0;
            rr_ptr_q       <= '0;
            prio_q         <= 1'b0;
            free_count_q   <= CW'(BUFS);
            almost_empty_q <= 1'b0;
            alloc_fail_q   <= 1'b0;
            rel_err_q      <= 1'b0;
        end else begin
            occupied_q     <= occupied_d;
            rr_ptr_q       <= rr_ptr_d;
            prio_q         <= prio_d;
            free_count_q   <= free_count_d;
            almost_empty_q <= almost_empty_d;
            alloc_fail_q   <= alloc_fail_d;
            rel_err_q      <= rel_err_d;
        end
    end

    assign free_count   = free_count_q;
    assign almost_empty = almost_empty_q;
    assign alloc_fail   = alloc_fail_q;
    assign rel_err      = rel_err_q;

endmodule

// File: tb/tb_rou_buf_alloc.sv
// Scoreboard bench for rou_buf_alloc (BUFS=8): each row drives one cycle and
// queues the same-cycle grant and the next-cycle registered status it should produce.
`timescale 1ns/1ps
module tb_rou_buf_alloc;
    localparam logic [5:0] NL = 6'd63;

    logic       clk = 1'b0;
    logic       rst, softreset, req0, req1, rel0, rel1;
    logic [5:0] rel0_idx, rel1_idx, idx0, idx1;
    logic       gnt0, gnt1, almost_empty, alloc_fail, rel_err;
    logic [3:0] free_count;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic rs, sr, r0, r1, l0;
        logic [5:0] l0i;
        logic l1;
        logic [5:0] l1i;
        logic eg0;
        logic [5:0] ei0;
        logic eg1;
        logic [5:0] ei1;
        logic [3:0] efc;
        logic eae, eaf, ere;
    } row_t;

    typedef struct packed { logic g0; logic [5:0] i0; logic g1; logic [5:0] i1; } gnt_t;
    typedef struct packed { logic [3:0] fc; logic ae, af, re; } st_t;

    gnt_t sb[$];
    st_t  st_q[$];

    always #5 clk = ~clk;

    rou_buf_alloc dut (
        .clk(clk), .rst(rst), .softreset(softreset),
        .req0(req0), .req1(req1), .gnt0(gnt0), .gnt1(gnt1),
        .idx0(idx0), .idx1(idx1),
        .rel0(rel0), .rel0_idx(rel0_idx), .rel1(rel1), .rel1_idx(rel1_idx),
        .free_count(free_count), .almost_empty(almost_empty),
        .alloc_fail(alloc_fail), .rel_err(rel_err)
    );

    function automatic row_t row(input logic rs, input logic sr, input logic r0, input logic r1,
                                 input logic l0, input logic [5:0] l0i,
                                 input logic l1, input logic [5:0] l1i,
                                 input logic eg0, input logic [5:0] ei0,
                                 input logic eg1, input logic [5:0] ei1,
                                 input logic [3:0] efc, input logic eae,
                                 input logic eaf, input logic ere);
        row_t r;
        r.rs = rs; r.sr = sr; r.r0 = r0; r.r1 = r1;
        r.l0 = l0; r.l0i = l0i; r.l1 = l1; r.l1i = l1i;
        r.eg0 = eg0; r.ei0 = ei0; r.eg1 = eg1; r.ei1 = ei1;
        r.efc = efc; r.eae = eae; r.eaf = eaf; r.ere = ere;
        return r;
    endfunction

    // Drive one cycle of stimulus and queue what it should produce.
    task automatic apply(input row_t r);
        rst = r.rs; softreset = r.sr; req0 = r.r0; req1 = r.r1;
        rel0 = r.l0; rel0_idx = r.l0i; rel1 = r.l1; rel1_idx = r.l1i;
        sb.push_back('{r.eg0, r.ei0, r.eg1, r.ei1});
        st_q.push_back('{r.efc, r.eae, r.eaf, r.ere});
    endtask

    task automatic test_reset();
        row_t rows[$];
        gnt_t g;
        st_t  s;
        rows.push_back(row(1, 0, 1, 1, 1, 0, 1, 0, 0, NL, 0, NL, 8, 0, 0, 0));
        rows.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, NL, 0, NL, 8, 0, 0, 0));
        foreach (rows[k]) begin
            apply(rows[k]);
            #1 g = sb.pop_front();
            n_checks++;
            if ({gnt0, idx0, gnt1, idx1} !== g) begin
                n_fail++;
                $display("FAIL reset[%0d] grant: got %b/%0d %b/%0d want %b/%0d %b/%0d", k, gnt0, idx0, gnt1, idx1, g.g0, g.i0, g.g1, g.i1);
            end
            @(posedge clk); #1 s = st_q.pop_front();
            n_checks++;
            if ({free_count, almost_empty, alloc_fail, rel_err} !== s) begin
                n_fail++;
                $display("FAIL reset[%0d] status: got fc=%0d ae=%b af=%b re=%b want fc=%0d ae=%b af=%b re=%b", k, free_count, almost_empty, alloc_fail, rel_err, s.fc, s.ae, s.af, s.re);
            end
            $display("reset[%0d] gnt0=%b idx0=%0d gnt1=%b idx1=%0d fc=%0d", k, gnt0, idx0, gnt1, idx1, free_count);
        end
    endtask

    task automatic test_fill();
        row_t rows[$];
        gnt_t g;
        st_t  s;
        for (int i = 0; i < 8; i++)
            rows.push_back(row(0, 0, 1, 0, 0, 0, 0, 0, 1, 6'(i), 0, NL, 4'(7 - i), (7 - i) <= 2, 0, 0));
        rows.push_back(row(0, 0, 1, 0, 0, 0, 0, 0, 0, NL, 0, NL, 0, 1, 1, 0));
        rows.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, NL, 0, NL, 0, 1, 0, 0));
        foreach (rows[k]) begin
            apply(rows[k]);
            #1 g = sb.pop_front();
            n_checks++;
            if ({gnt0, idx0, gnt1, idx1} !== g) begin
                n_fail++;
                $display("FAIL fill[%0d] grant: got %b/%0d %b/%0d want %b/%0d %b/%0d", k, gnt0, idx0, gnt1, idx1, g.g0, g.i0, g.g1, g.i1);
            end
            @(posedge clk); #1 s = st_q.pop_front();
            n_checks++;
            if ({free_count, almost_empty, alloc_fail, rel_err} !== s) begin
                n_fail++;
                $display("FAIL fill[%0d] status: got fc=%0d ae=%b af=%b re=%b want fc=%0d ae=%b af=%b re=%b", k, free_count, almost_empty, alloc_fail, rel_err, s.fc, s.ae, s.af, s.re);
            end
            $display("fill[%0d] gnt0=%b idx0=%0d fc=%0d af=%b", k, gnt0, idx0, free_count, alloc_fail);
        end
    endtask

    task automatic test_pairs();
        row_t rows[$];
        gnt_t g;
        st_t  s;
        rows.push_back(row(1, 0, 0, 0, 0, 0, 0, 0, 0, NL, 0, NL, 8, 0, 0, 0));
        rows.push_back(row(0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 1, 1, 6, 0, 0, 0));
        rows.push_back(row(0, 0, 1, 1, 0, 0, 0, 0, 1, 3, 1, 2, 4, 0, 0, 0));
        rows.push_back(row(0, 0, 1, 1, 0, 0, 0, 0, 1, 4, 1, 5, 2, 1, 0, 0));
        rows.push_back(row(0, 0, 1, 1, 0, 0, 0, 0, 1, 7, 1, 6, 0, 1, 0, 0));
        foreach (rows[k]) begin
            apply(rows[k]);
            #1 g = sb.pop_front();
            n_checks++;
            if ({gnt0, idx0, gnt1, idx1} !== g) begin
                n_fail++;
                $display("FAIL pairs[%0d] grant: got %b/%0d %b/%0d want %b/%0d %b/%0d", k, gnt0, idx0, gnt1, idx1, g.g0, g.i0, g.g1, g.i1);
            end
            @(posedge clk); #1 s = st_q.pop_front();
            n_checks++;
            if ({free_count, almost_empty, alloc_fail, rel_err} !== s) begin
                n_fail++;
                $display("FAIL pairs[%0d] status: got fc=%0d ae=%b af=%b re=%b want fc=%0d ae=%b af=%b re=%b", k, free_count, almost_empty, alloc_fail, rel_err, s.fc, s.ae, s.af, s.re);
            end
            $display("pairs[%0d] gnt0=%b idx0=%0d gnt1=%b idx1=%0d fc=%0d", k, gnt0, idx0, gnt1, idx1, free_count);
        end
    endtask

    // Pool full, rr_ptr=0, prio=0 on entry.
    task automatic test_last_slot();
        row_t rows[$];
        gnt_t g;
        st_t  s;
        rows.push_back(row(0, 0, 0, 0, 1, 5, 0, 0, 0, NL, 0, NL, 1, 1, 0, 0));
        rows.push_back(row(0, 0, 1, 1, 0, 0, 0, 0, 1, 5, 0, NL, 0, 1, 1, 0));
        rows.push_back(row(0, 0, 0, 0, 0, 0, 1, 5, 0, NL, 0, NL, 1, 1, 0, 0));
        rows.push_back(row(0, 0, 1, 1, 0, 0, 0, 0, 0, NL, 1, 5, 0, 1, 1, 0));
        foreach (rows[k]) begin
            apply(rows[k]);
            #1 g = sb.pop_front();
            n_checks++;
            if ({gnt0, idx0, gnt1, idx1} !== g) begin
                n_fail++;
                $display("FAIL last_slot[%0d] grant: got %b/%0d %b/%0d want %b/%0d %b/%0d", k, gnt0, idx0, gnt1, idx1, g.g0, g.i0, g.g1, g.i1);
            end
            @(posedge clk); #1 s = st_q.pop_front();
            n_checks++;
            if ({free_count, almost_empty, alloc_fail, rel_err} !== s) begin
                n_fail++;
                $display("FAIL last_slot[%0d] status: got fc=%0d ae=%b af=%b re=%b want fc=%0d ae=%b af=%b re=%b", k, free_count, almost_empty, alloc_fail, rel_err, s.fc, s.ae, s.af, s.re);
            end
            $display("last_slot[%0d] gnt0=%b idx0=%0d gnt1=%b idx1=%0d af=%b", k, gnt0, idx0, gnt1, idx1, alloc_fail);
        end
    endtask

    // Pool full, rr_ptr=6 on entry.
    task automatic test_rel_same_cycle();
        row_t rows[$];
        gnt_t g;
        st_t  s;
        rows.push_back(row(0, 0, 1, 0, 1, 3, 0, 0, 0, NL, 0, NL, 1, 1, 1, 0));
        rows.push_back(row(0, 0, 1, 0, 0, 0, 0, 0, 1, 3, 0, NL, 0, 1, 0, 0));
        foreach (rows[k]) begin
            apply(rows[k]);
            #1 g = sb.pop_front();
            n_checks++;
            if ({gnt0, idx0, gnt1, idx1} !== g) begin
                n_fail++;
                $display("FAIL rel_same[%0d] grant: got %b/%0d %b/%0d want %b/%0d %b/%0d", k, gnt0, idx0, gnt1, idx1, g.g0, g.i0, g.g1, g.i1);
            end
            @(posedge clk); #1 s = st_q.pop_front();
            n_checks++;
            if ({free_count, almost_empty, alloc_fail, rel_err} !== s) begin
                n_fail++;
                $display("FAIL rel_same[%0d] status: got fc=%0d ae=%b af=%b re=%b want fc=%0d ae=%b af=%b re=%b", k, free_count, almost_empty, alloc_fail, rel_err, s.fc, s.ae, s.af, s.re);
            end
            $display("rel_same[%0d] gnt0=%b idx0=%0d fc=%0d", k, gnt0, idx0, free_count);
        end
    endtask

    task automatic test_double_release();
        row_t rows[$];
        gnt_t g;
        st_t  s;
        rows.push_back(row(0, 0, 0, 0, 1, 2, 1, 2, 0, NL, 0, NL, 1, 1, 0, 1));
        rows.push_back(row(0, 0, 0, 0, 1, 2, 0, 0, 0, NL, 0, NL, 1, 1, 0, 1));
        rows.push_back(row(0, 0, 0, 0, 0, 0, 1, 9, 0, NL, 0, NL, 1, 1, 0, 1));
        rows.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, NL, 0, NL, 1, 1, 0, 0));
        foreach (rows[k]) begin
            apply(rows[k]);
            #1 g = sb.pop_front();
            n_checks++;
            if ({gnt0, idx0, gnt1, idx1} !== g) begin
                n_fail++;
                $display("FAIL dbl_rel[%0d] grant: got %b/%0d %b/%0d want %b/%0d %b/%0d", k, gnt0, idx0, gnt1, idx1, g.g0, g.i0, g.g1, g.i1);
            end
            @(posedge clk); #1 s = st_q.pop_front();
            n_checks++;
            if ({free_count, almost_empty, alloc_fail, rel_err} !== s) begin
                n_fail++;
                $display("FAIL dbl_rel[%0d] status: got fc=%0d ae=%b af=%b re=%b want fc=%0d ae=%b af=%b re=%b", k, free_count, almost_empty, alloc_fail, rel_err, s.fc, s.ae, s.af, s.re);
            end
            $display("dbl_rel[%0d] fc=%0d rel_err=%b", k, free_count, rel_err);
        end
    endtask

    task automatic test_softreset();
        row_t rows[$];
        gnt_t g;
        st_t  s;
        rows.push_back(row(0, 1, 1, 0, 0, 0, 0, 0, 0, NL, 0, NL, 8, 0, 0, 0));
        for (int i = 0; i < 5; i++)
            rows.push_back(row(0, 0, 1, 0, 0, 0, 0, 0, 1, 6'(i), 0, NL, 4'(7 - i), 0, 0, 0));
        rows.push_back(row(0, 1, 1, 0, 0, 0, 0, 0, 0, NL, 0, NL, 8, 0, 0, 0));
        rows.push_back(row(0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, NL, 7, 0, 0, 0));
        rows.push_back(row(0, 0, 0, 0, 1, 3, 0, 0, 0, NL, 0, NL, 7, 0, 0, 1));
        foreach (rows[k]) begin
            apply(rows[k]);
            #1 g = sb.pop_front();
            n_checks++;
            if ({gnt0, idx0, gnt1, idx1} !== g) begin
                n_fail++;
                $display("FAIL softreset[%0d] grant: got %b/%0d %b/%0d want %b/%0d %b/%0d", k, gnt0, idx0, gnt1, idx1, g.g0, g.i0, g.g1, g.i1);
            end
            @(posedge clk); #1 s = st_q.pop_front();
            n_checks++;
            if ({free_count, almost_empty, alloc_fail, rel_err} !== s) begin
                n_fail++;
                $display("FAIL softreset[%0d] status: got fc=%0d ae=%b af=%b re=%b want fc=%0d ae=%b af=%b re=%b", k, free_count, almost_empty, alloc_fail, rel_err, s.fc, s.ae, s.af, s.re);
            end
            $display("softreset[%0d] gnt0=%b idx0=%0d fc=%0d rel_err=%b", k, gnt0, idx0, free_count, rel_err);
        end
    endtask

    // Slot 0 occupied, rr_ptr=1, prio=0 on entry; finishes with rst mid-burst.
    task automatic test_back_to_back();
        row_t rows[$];
        gnt_t g;
        st_t  s;
        rows.push_back(row(0, 0, 1, 0, 1, 0, 0, 0, 1, 1, 0, NL, 7, 0, 0, 0));
        rows.push_back(row(0, 0, 1, 1, 0, 0, 0, 0, 1, 2, 1, 3, 5, 0, 0, 0));
        rows.push_back(row(1, 0, 1, 1, 0, 0, 0, 0, 0, NL, 0, NL, 8, 0, 0, 0));
        rows.push_back(row(0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, NL, 7, 0, 0, 0));
        rows.push_back(row(0, 0, 0, 0, 1, 2, 0, 0, 0, NL, 0, NL, 7, 0, 0, 1));
        foreach (rows[k]) begin
            apply(rows[k]);
            #1 g = sb.pop_front();
            n_checks++;
            if ({gnt0, idx0, gnt1, idx1} !== g) begin
                n_fail++;
                $display("FAIL b2b[%0d] grant: got %b/%0d %b/%0d want %b/%0d %b/%0d", k, gnt0, idx0, gnt1, idx1, g.g0, g.i0, g.g1, g.i1);
            end
            @(posedge clk); #1 s = st_q.pop_front();
            n_checks++;
            if ({free_count, almost_empty, alloc_fail, rel_err} !== s) begin
                n_fail++;
                $display("FAIL b2b[%0d] status: got fc=%0d ae=%b af=%b re=%b want fc=%0d ae=%b af=%b re=%b", k, free_count, almost_empty, alloc_fail, rel_err, s.fc, s.ae, s.af, s.re);
            end
            $display("b2b[%0d] gnt0=%b idx0=%0d gnt1=%b idx1=%0d fc=%0d", k, gnt0, idx0, gnt1, idx1, free_count);
        end
    endtask

    initial begin
        rst = 1'b1; softreset = 1'b0; req0 = 1'b0; req1 = 1'b0;
        rel0 = 1'b0; rel1 = 1'b0; rel0_idx = '0; rel1_idx = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_fill();
        test_pairs();
        test_last_slot();
        test_rel_same_cycle();
        test_double_release();
        test_softreset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
